line_clear_sequencer: RTL and testbench

Sequences the row-clear animation and board collapse for the Tetris play field shown by `VGAdisplay`. When the game logic locks a piece it hands over the 10×20 board. The block finds full rows, drives the display's per-cell flash mask for a timed blink, then compacts the board one row per cycle and returns it with the cleared-line count. It sits between the game-state logic and `VGAdisplay`, supplying the `flash` mask that the display's `en_flash` path consumes.

---
 rtl/line_clear_sequencer.sv | 139 +++++++++++++
 tb/tb_line_clear_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_clear_sequencer.sv
// Detects full rows of the 10x20 play field, blinks them through the flash mask,
// then compacts the board one row per cycle and reports the number of lines removed.
module line_clear_sequencer #(
  parameter int FLASH_TICKS   = 15,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         tick,
  input  logic         start,
  input  logic [199:0] matrix_in,
  output logic [199:0] matrix_out,
  output logic [199:0] flash,
  output logic         busy,
  output logic         done,
  output logic [2:0]   lines_cleared
);

  localparam int TICK_W = (FLASH_TICKS   > 1) ? $clog2(FLASH_TICKS + 1)   : 1;
  localparam int TOG_W  = (FLASH_TOGGLES > 1) ? $clog2(FLASH_TOGGLES + 1) : 1;

  typedef enum logic [2:0] {IDLE, SCAN, FLASH, COLLAPSE, FILL, DONE} state_t;

  state_t              state, state_next;
  logic [199:0]        board;
  logic [19:0]         full_rows;
  logic [19:0]         row_full;
  logic [4:0]          pop;
  logic [2:0]          lines_next;
  logic [TICK_W-1:0]   tick_cnt;
  logic [TOG_W-1:0]    toggle_cnt;
  logic                phase;
  logic [4:0]          rd;
  logic [4:0]          wr;
  logic [2:0]          fill_cnt;
  logic                tick_wrap;
  logic                last_toggle;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    row_full = '0;
    pop      = '0;
    for (int r = 0; r < 20; r++) begin
      row_full[r] = &board[r*10 +: 10];
      pop         = pop + 5'(row_full[r]);
    end
    lines_next = (pop > 5'd4) ? 3'd4 : pop[2:0];
  end

  assign tick_wrap   = tick && (tick_cnt == TICK_W'(FLASH_TICKS - 1));
  assign last_toggle = tick_wrap && (toggle_cnt == TOG_W'(FLASH_TOGGLES - 1));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = SCAN;
      SCAN:     state_next = (row_full == '0) ? DONE : FLASH;
      FLASH:    if (last_toggle) state_next = COLLAPSE;
      COLLAPSE: if (rd == 5'd0) state_next = FILL;
      FILL:     if (fill_cnt + 3'd1 == lines_cleared) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent races.
  // The board is an ordinary register (not a RAM), so it is cleared on reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      board         <= '0;
      full_rows     <= '0;
      lines_cleared <= '0;
      tick_cnt      <= '0;
      toggle_cnt    <= '0;
      phase         <= 1'b0;
      rd            <= '0;
      wr            <= '0;
      fill_cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (start) board <= matrix_in;
        SCAN: begin
          full_rows     <= row_full;
          lines_cleared <= lines_next;
          phase         <= 1'b1;
          tick_cnt      <= '0;
          toggle_cnt    <= '0;
          rd            <= 5'd19;
          wr            <= 5'd19;
          fill_cnt      <= '0;
        end
        FLASH: if (tick) begin
          if (tick_wrap) begin
            tick_cnt   <= '0;
            toggle_cnt <= toggle_cnt + TOG_W'(1);
            phase      <= last_toggle ? 1'b0 : ~phase;
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        COLLAPSE: begin
          // Surviving rows slide down to the write index; full rows are skipped.
          if (!full_rows[rd]) begin
            board[int'(wr)*10 +: 10] <= board[int'(rd)*10 +: 10];
            wr                       <= wr - 5'd1;
          end
          rd <= rd - 5'd1;
        end
        FILL: begin
          board[int'(wr)*10 +: 10] <= '0;
          wr                       <= wr - 5'd1;
          fill_cnt                 <= fill_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    flash = '0;
    if (state == FLASH && phase) begin
      for (int r = 0; r < 20; r++) begin
        if (full_rows[r]) flash[r*10 +: 10] = '1;
      end
    end
  end

  assign matrix_out = board;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_line_clear_sequencer.sv
// Scoreboard bench for line_clear_sequencer with short flash timing (2 ticks x 2 toggles).
module tb_line_clear_sequencer;

  localparam int FT = 2;
  localparam int FG = 2;

  logic         clk = 1'b0;
  logic         clrn = 1'b0;
  logic         tick = 1'b0;
  logic         start = 1'b0;
  logic [199:0] matrix_in = '0;
  logic [199:0] matrix_out;
  logic [199:0] flash;
  logic         busy;
  logic         done;
  logic [2:0]   lines_cleared;

  line_clear_sequencer #(.FLASH_TICKS(FT), .FLASH_TOGGLES(FG)) dut (
    .clk(clk), .clrn(clrn), .tick(tick), .start(start), .matrix_in(matrix_in),
    .matrix_out(matrix_out), .flash(flash), .busy(busy), .done(done),
    .lines_cleared(lines_cleared)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [199:0] board;
    logic [2:0]   lines;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [199:0] row_mask(input logic [199:0] b);
    logic [199:0] m = '0;
    for (int r = 0; r < 20; r++) if (b[r*10 +: 10] == 10'h3FF) m[r*10 +: 10] = '1;
    return m;
  endfunction

  function automatic exp_t model(input logic [199:0] b);
    exp_t e;
    int   w = 19;
    int   n = 0;
    e.board = '0;
    for (int r = 19; r >= 0; r--) begin
      if (b[r*10 +: 10] == 10'h3FF) n++;
      else begin
        e.board[w*10 +: 10] = b[r*10 +: 10];
        w--;
      end
    end
    e.lines = (n > 4) ? 3'd4 : 3'(n);
    return e;
  endfunction

  task automatic test_reset();
    start = 1'b1;
    matrix_in = {200{1'b1}};
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++;
      $display("FAIL reset_ctrl busy=%b done=%b want 0 0", busy, done); end
    tests++; if (matrix_out !== '0 || flash !== '0 || lines_cleared !== 3'd0) begin fails++;
      $display("FAIL reset_data out=%h flash=%h lines=%0d want all 0", matrix_out, flash, lines_cleared); end
    start = 1'b0;
    clrn = 1'b1;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++;
      $display("FAIL reset_release busy=%b want 0", busy); end
  endtask

  // Full flash/collapse run: checks flash mask per phase, latency and the popped result.
  task automatic run_case(input string name, input logic [199:0] b,
                          input logic [199:0] exp_board, input logic [2:0] exp_lines,
                          input bit poke);
    exp_t         e;
    logic [199:0] mask = row_mask(b);
    int           lat = 0;
    e.board = exp_board;
    e.lines = exp_lines;
    sb.push_back(e);
    matrix_in = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++;
      $display("FAIL %s_scan busy=%b done=%b want 1 0", name, busy, done); end
    @(negedge clk);
    tests++; if (flash !== mask) begin fails++;
      $display("FAIL %s_flash_on got=%h want=%h", name, flash, mask); end
    tests++; if (matrix_out !== b || lines_cleared !== exp_lines) begin fails++;
      $display("FAIL %s_hold out=%h lines=%0d want out=%h lines=%0d", name, matrix_out, lines_cleared, b, exp_lines); end
    tick = 1'b1;
    if (poke) begin start = 1'b1; matrix_in = ~b; end
    @(negedge clk);
    start = 1'b0;
    tests++; if (flash !== mask) begin fails++;
      $display("FAIL %s_flash_on2 got=%h want=%h", name, flash, mask); end
    @(negedge clk);
    tests++; if (flash !== '0) begin fails++;
      $display("FAIL %s_flash_off got=%h want 0", name, flash); end
    repeat (2) @(negedge clk);
    tick = 1'b0;
    tests++; if (flash !== '0 || busy !== 1'b1) begin fails++;
      $display("FAIL %s_collapse_entry flash=%h busy=%b want 0 1", name, flash, busy); end
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      if (poke && c == 5) begin start = 1'b1; matrix_in = ~b; end
      @(negedge clk);
      start = 1'b0;
      if (done) lat = c;
    end
    e = sb.pop_front();
    tests++; if (lat != 20 + int'(e.lines)) begin fails++;
      $display("FAIL %s_latency got=%0d want=%0d", name, lat, 20 + int'(e.lines)); end
    tests++; if (matrix_out !== e.board) begin fails++;
      $display("FAIL %s_board got=%h want=%h", name, matrix_out, e.board); end
    tests++; if (lines_cleared !== e.lines || busy !== 1'b1) begin fails++;
      $display("FAIL %s_lines got=%0d busy=%b want %0d 1", name, lines_cleared, busy, e.lines); end
    @(negedge clk);
    tests++; if (done !== 1'b0 || busy !== 1'b0 || matrix_out !== e.board) begin fails++;
      $display("FAIL %s_idle done=%b busy=%b out=%h", name, done, busy, matrix_out); end
  endtask

  task automatic test_no_full();
    logic [199:0] b = '0;
    exp_t         e;
    b[195] = 1'b1;
    e.board = b;
    e.lines = 3'd0;
    sb.push_back(e);
    matrix_in = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++; if (busy !== 1'b1 || done !== 1'b0 || flash !== '0) begin fails++;
      $display("FAIL nofull_scan busy=%b done=%b flash=%h", busy, done, flash); end
    @(negedge clk);
    e = sb.pop_front();
    tests++; if (done !== 1'b1 || busy !== 1'b1 || flash !== '0) begin fails++;
      $display("FAIL nofull_done done=%b busy=%b flash=%h want 1 1 0", done, busy, flash); end
    tests++; if (matrix_out !== e.board || lines_cleared !== e.lines) begin fails++;
      $display("FAIL nofull_result out=%h lines=%0d want out=%h lines=%0d", matrix_out, lines_cleared, e.board, e.lines); end
    start = 1'b1;
    matrix_in = {200{1'b1}};
    @(negedge clk);
    start = 1'b0;
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++;
      $display("FAIL nofull_idle done=%b busy=%b want 0 0", done, busy); end
    @(negedge clk);
    tests++; if (busy !== 1'b0 || matrix_out !== e.board) begin fails++;
      $display("FAIL start_on_done busy=%b out=%h want 0 %h", busy, matrix_out, e.board); end
  endtask

  task automatic test_reset_mid_flash(input logic [199:0] b);
    matrix_in = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    repeat (2) @(negedge clk);
    tick = 1'b0;
    tests++; if (busy !== 1'b1 || matrix_out !== b) begin fails++;
      $display("FAIL midflash_pre busy=%b out=%h", busy, matrix_out); end
    #2 clrn = 1'b0;
    #1;
    tests++; if (flash !== '0 || matrix_out !== '0 || busy !== 1'b0 || lines_cleared !== 3'd0) begin fails++;
      $display("FAIL midflash_reset flash=%h out=%h busy=%b lines=%0d want 0", flash, matrix_out, busy, lines_cleared); end
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [199:0] b;
    logic [199:0] x;
    exp_t         e;

    test_reset();

    b = '0; b[199:190] = '1; b[185] = 1'b1;
    x = '0; x[195] = 1'b1;
    run_case("single", b, x, 3'd1, 1'b0);

    test_no_full();

    b = '0; b[199:190] = '1; b[179:170] = '1; b[180] = 1'b1; b[169] = 1'b1;
    x = '0; x[190] = 1'b1; x[189] = 1'b1;
    run_case("nonadj", b, x, 3'd2, 1'b0);

    b = '0; b[199:160] = '1; b[159:150] = 10'h3EF;
    x = '0; x[199:190] = 10'h3EF;
    run_case("tetris", b, x, 3'd4, 1'b0);

    b = '0; b[199:190] = '1; b[185] = 1'b1; b[3] = 1'b1;
    x = '0; x[195] = 1'b1; x[13] = 1'b1;
    run_case("start_busy", b, x, 3'd1, 1'b1);

    test_reset_mid_flash(b);
    run_case("after_reset", b, x, 3'd1, 1'b0);

    for (int k = 0; k < 3; k++) begin
      b = '0;
      for (int r = 0; r < 20; r++) begin
        b[r*10 +: 10] = 10'($urandom);
        if (b[r*10 +: 10] == 10'h3FF) b[r*10] = 1'b0;
      end
      for (int f = 0; f < 1 + k; f++) b[$urandom_range(0, 19)*10 +: 10] = '1;
      e = model(b);
      run_case("random", b, e.board, e.lines, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
